// File: rtl/ps2_keyboard_redbus.sv
// PS/2 keyboard Redbus device: filtered PS/2 frame receiver feeding a scancode FIFO,
// exposed to the CPU as status/head/control registers on the shared Redbus.
module ps2_keyboard_redbus #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Address,
  inout  wire  [7:0]  Data,
  input  logic        Read,
  input  logic        Write,
  input  logic        Enable,
  input  logic        Ps2Clk,
  input  logic        Ps2Data,
  output logic        KeyAvail
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {RX_IDLE, RX_DATA} rx_state_t;

  rx_state_t       rx_state_q, rx_state_d;
  logic [1:0]      clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic            filt_q, filt_d;
  logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic            ovf_q, ovf_d, perr_q, perr_d;
  logic            rd_term_q, rd_term_d, wr_term_q, wr_term_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            ps2_fall, ps2_edge, ps2_bit, rx_timeout;
  logic            rx_push, rx_err;
  logic            pop_req, wr_fire, flush, clr;
  logic            empty, full, do_pop, do_push, mem_we, ovf_set;
  logic [PW-1:0]   wr_ptr_inc, rd_ptr_inc;
  logic [8:0]      count_wide;
  logic [3:0]      count_sat;
  logic [7:0]      status, head, rd_val;
  logic            unused_bits;

  assign unused_bits = ^{Address[15:8], Data[7:2]};

  // Filter: the line must disagree with the filtered value for FILTER_LEN samples in a row.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], Ps2Clk};
    dat_sync_d = {dat_sync_q[0], Ps2Data};
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_sync_q[1];
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign ps2_fall   = filt_q & ~filt_d;
  assign ps2_edge   = filt_q ^ filt_d;
  assign ps2_bit    = dat_sync_q[1];
  assign rx_timeout = (to_cnt_q == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) rx_state_q <= RX_IDLE;
    else        rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: if (ps2_fall && !ps2_bit) rx_state_d = RX_DATA;
      RX_DATA: begin
        if (ps2_fall && bit_cnt_q == 4'd10)  rx_state_d = RX_IDLE;
        else if (!ps2_edge && rx_timeout)    rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Bit 10 is the stop bit; frame is good when stop=1 and data+parity has odd weight.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    rx_push   = 1'b0;
    rx_err    = 1'b0;
    to_cnt_d  = (rx_state_q == RX_DATA && !ps2_edge) ? to_cnt_q + 1'b1 : '0;
    case (rx_state_q)
      RX_IDLE: if (ps2_fall && !ps2_bit) bit_cnt_d = 4'd1;
      RX_DATA: begin
        if (ps2_fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q <= 4'd8)       shift_d = {ps2_bit, shift_q[7:1]};
          else if (bit_cnt_q == 4'd9)  par_d = ps2_bit;
          else begin
            bit_cnt_d = 4'd0;
            if (ps2_bit && ^{shift_q, par_q}) rx_push = 1'b1;
            else                              rx_err  = 1'b1;
          end
        end
      end
      default: bit_cnt_d = 4'd0;
    endcase
  end

  // Pop on the trailing edge of a head read; control acts on the leading edge of a write.
  assign rd_term_d = Enable & Read  & (Address[7:0] == 8'h01);
  assign wr_term_d = Enable & Write & (Address[7:0] == 8'h02);
  assign pop_req   = rd_term_q & ~rd_term_d;
  assign wr_fire   = wr_term_d & ~wr_term_q;
  assign flush     = wr_fire & Data[0];
  assign clr       = wr_fire & Data[1];

  assign empty      = (count_q == '0);
  assign full       = (count_q == PW'(FIFO_DEPTH));
  assign do_pop     = pop_req & ~empty;
  assign do_push    = rx_push & (~full | do_pop);
  assign mem_we     = do_push & ~flush;
  assign ovf_set    = rx_push & full & ~do_pop & ~flush;
  assign wr_ptr_inc = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
  assign rd_ptr_inc = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_inc;
      if (do_pop)  rd_ptr_d = rd_ptr_inc;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    ovf_d  = (ovf_q  & ~clr) | ovf_set;
    perr_d = (perr_q & ~clr) | rx_err;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
      rd_term_q  <= 1'b0;
      wr_term_q  <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      perr_q     <= perr_d;
      rd_term_q  <= rd_term_d;
      wr_term_q  <= wr_term_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign count_wide = 9'(count_q);
  assign count_sat  = (count_wide > 9'd15) ? 4'hF : count_wide[3:0];
  assign status     = {count_sat, 1'b0, perr_q, ovf_q, ~empty};
  assign head       = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign KeyAvail   = ~empty;

  always_comb begin
    rd_val = 8'h00;
    case (Address[7:0])
      8'h00:   rd_val = status;
      8'h01:   rd_val = head;
      default: rd_val = 8'h00;
    endcase
  end

  // Reset is in the enable so the bus is released asynchronously.
  assign Data = (Reset & Enable & Read) ? rd_val : 8'hzz;
endmodule

// File: tb/tb_ps2_keyboard_redbus.sv
// Directed bench for ps2_keyboard_redbus: PS/2 frame driver, Redbus read/write tasks,
// and an expected-scancode queue with flag model checked on every register read.
module tb_ps2_keyboard_redbus;
  localparam int TO = 5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic        rd, wr, en, ps2_clk, ps2_dat;
  logic        key_avail;
  logic        drv_en;
  logic [7:0]  drv_val;
  wire  [7:0]  data_bus;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  bit          m_ovf, m_perr;
  logic [7:0]  v, e;

  always #5 clk = ~clk;

  assign data_bus = drv_en ? drv_val : 8'hzz;
  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_pull
      pullup pu (data_bus[g]);
    end
  endgenerate

  ps2_keyboard_redbus #(.FIFO_DEPTH(16), .FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(clk), .Reset(rst_n), .Address(addr), .Data(data_bus), .Read(rd),
    .Write(wr), .Enable(en), .Ps2Clk(ps2_clk), .Ps2Data(ps2_dat), .KeyAvail(key_avail)
  );

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    int n;
    logic [3:0] c;
    n = exp_q.size();
    c = (n > 15) ? 4'hF : 4'(n);
    return {c, 1'b0, m_perr, m_ovf, n != 0};
  endfunction

  task automatic ps2_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      repeat (8) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (16) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~^b;
    if (bad_par) par = ~par;
    if (bad_par) m_perr = 1'b1;
    else if (exp_q.size() < 16) exp_q.push_back(b);
    else m_ovf = 1'b1;
    ps2_bits({1'b1, par, b, 1'b0}, 11);
    ps2_dat = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] val);
    @(negedge clk);
    en = 1'b1; rd = 1'b1; addr = {8'h00, a};
    @(negedge clk);
    val = data_bus;
    en = 1'b0; rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] val);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = {8'h00, a}; drv_en = 1'b1; drv_val = val;
    @(negedge clk);
    en = 1'b0; wr = 1'b0; drv_en = 1'b0;
    @(negedge clk);
    if (a == 8'h02) begin
      if (val[0]) exp_q.delete();
      if (val[1]) begin m_ovf = 1'b0; m_perr = 1'b0; end
    end
  endtask

  task automatic read_status(input string tag);
    logic [7:0] r;
    bus_read(8'h00, r);
    check8(tag, r, exp_status());
  endtask

  task automatic read_head(input string tag);
    logic [7:0] r, x;
    x = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    bus_read(8'h01, r);
    check8(tag, r, x);
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; rd = 0; wr = 0; en = 0; ps2_clk = 1; ps2_dat = 1;
    drv_en = 0; drv_val = '0; m_ovf = 0; m_perr = 0;
    repeat (4) @(negedge clk);
    check8("reset_keyavail", {7'b0, key_avail}, 8'h00);
    check8("reset_bus_z", data_bus, 8'hFF);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    read_status("reset_status");

    // single valid frame
    send_frame(8'h1C, 1'b0);
    check8("t1_status_const", exp_status(), 8'h11);
    read_status("t1_status");
    check8("t1_keyavail", {7'b0, key_avail}, 8'h01);
    read_head("t1_head");
    read_status("t1_status_empty");

    // overflow: 17 unique frames, 16 kept
    for (int i = 0; i < 17; i++) send_frame(8'(8'h40 + i), 1'b0);
    read_status("t2_status_full");
    for (int i = 0; i < 16; i++) read_head("t2_head");
    read_head("t2_head_empty");
    read_status("t2_status_ovf");
    bus_write(8'h02, 8'h02);
    read_status("t2_status_clr");

    // parity error
    send_frame(8'h5A, 1'b1);
    read_status("t3_status_perr");
    bus_write(8'h02, 8'h02);
    read_status("t3_status_clr");

    // timeout drops a partial frame
    ps2_bits(11'b000_0010_1010, 6);
    ps2_dat = 1'b1;
    repeat (TO + 100) @(negedge clk);
    send_frame(8'h29, 1'b0);
    read_status("t4_status");
    read_head("t4_head");
    read_status("t4_status_empty");

    // long read pops once and holds its value
    send_frame(8'($urandom_range(0, 255)), 1'b0);
    send_frame(8'($urandom_range(0, 255)), 1'b0);
    @(negedge clk);
    en = 1'b1; rd = 1'b1; addr = 16'h0001;
    e = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check8("t5_hold_stable", data_bus, e);
    end
    en = 1'b0; rd = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    read_status("t5_status_one_pop");
    @(negedge clk);
    rd = 1'b1; addr = 16'h0000;
    #1 check8("t5_z_enable0", data_bus, 8'hFF);
    rd = 1'b0; en = 1'b1;
    #1 check8("t5_z_read0", data_bus, 8'hFF);
    en = 1'b0;
    read_head("t5_head_second");

    // unmapped accesses and flush
    send_frame(8'h11, 1'b0);
    send_frame(8'h22, 1'b0);
    bus_write(8'h03, 8'h01);
    read_status("flush_pre_status");
    bus_read(8'h05, v);
    check8("unmapped_read", v, 8'h00);
    bus_write(8'h02, 8'h01);
    read_status("flush_status");

    // reset mid-frame and mid-read with three bytes queued
    for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 1'b0);
    ps2_bits(11'b000_0000_0110, 4);
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    repeat (12) @(negedge clk);
    en = 1'b1; rd = 1'b1; addr = 16'h0000;
    #1 check8("t6_status_before", data_bus, exp_status());
    #2 rst_n = 1'b0;
    #1 check8("t6_bus_z_async", data_bus, 8'hFF);
    check8("t6_keyavail", {7'b0, key_avail}, 8'h00);
    exp_q.delete(); m_ovf = 0; m_perr = 0;
    en = 1'b0; rd = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    read_status("t6_status_after");
    send_frame(8'h77, 1'b0);
    read_status("t6_status_new");
    read_head("t6_head_new");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
